// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared constants and types for the hex keypad entry block.
//   - buffer geometry (digits, digit width, counter width)
//   - default debounce length for a 50 MHz board clock
//   - key event encoding and the same-cycle priority resolver
package hex_entry_pkg;

    localparam int NUM_DIGITS              = 8;
    localparam int DIGIT_W                 = 4;
    localparam int COUNT_W                 = 4;
    localparam int VALUE_W                 = NUM_DIGITS * DIGIT_W;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Event selected in a cycle; higher encodings win when pulses coincide.
    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_ENTER  = 2'd1,
        EV_COMMIT = 2'd2,
        EV_CLEAR  = 2'd3
    } event_e;

    // Resolve coincident press pulses: clear beats commit beats enter.
    function automatic event_e select_event(input logic clear_p,
                                            input logic commit_p,
                                            input logic enter_p);
        event_e ev;
        if (clear_p) begin
            ev = EV_CLEAR;
        end else if (commit_p) begin
            ev = EV_COMMIT;
        end else if (enter_p) begin
            ev = EV_ENTER;
        end else begin
            ev = EV_NONE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   2-flop synchronizer -> stable-level filter -> falling-edge pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw button level (asynchronous to clk), low = pressed
//   level      : debounced button level, 1 = released
//   press      : one-cycle pulse on each debounced press (registered)
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q,  sync_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: the counter runs only while the synchronized input disagrees
    // with the debounced level; the level flips on the last disagreeing cycle.
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Pulse is registered together with the falling level.
        press_d = level_q & ~level_d;
    end

    // State registers; released (1) is the reset level so reset never fakes a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/hex_entry.sv
// hex_entry: builds a 32-bit hex word from a switch nibble, one digit per
// debounced button press, and hands finished words out over valid/ready.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sw[3:0]           : digit to enter
//   key_enter_n       : raw button, shift sw into the buffer
//   key_clear_n       : raw button, clear the buffer
//   key_commit_n      : raw button, copy the buffer to commit_data
//   value[31:0]       : live entry buffer, digit 0 in value[3:0]
//   digit_count[3:0]  : digits entered since the last clear, saturates at 8
//   commit_data[31:0] : committed word, held while commit_valid
//   commit_valid      : committed word available
//   commit_ready      : consumer accepts when high with commit_valid
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] sw,
    input  logic               key_enter_n,
    input  logic               key_clear_n,
    input  logic               key_commit_n,
    output logic [VALUE_W-1:0] value,
    output logic [COUNT_W-1:0] digit_count,
    output logic [VALUE_W-1:0] commit_data,
    output logic               commit_valid,
    input  logic               commit_ready
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_DIGITS);

    logic enter_p_s, clear_p_s, commit_p_s;
    logic enter_lvl_s, clear_lvl_s, commit_lvl_s;
    logic unused_levels_s;
    event_e ev_s;

    logic [VALUE_W-1:0] value_q,  value_d;
    logic [COUNT_W-1:0] count_q,  count_d;
    logic [VALUE_W-1:0] cdata_q,  cdata_d;
    logic               cvalid_q, cvalid_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .level (enter_lvl_s),
        .press (enter_p_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clear_n),
        .level (clear_lvl_s),
        .press (clear_p_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_commit_n),
        .level (commit_lvl_s),
        .press (commit_p_s)
    );

    // Debounced levels are not needed here; only the press pulses drive actions.
    assign unused_levels_s = enter_lvl_s ^ clear_lvl_s ^ commit_lvl_s;

    // Next-state for buffer, counter and commit register.
    always_comb begin
        ev_s     = select_event(clear_p_s, commit_p_s, enter_p_s);
        value_d  = value_q;
        count_d  = count_q;
        cdata_d  = cdata_q;
        // Accepted word retires; a commit below may reload it in the same cycle.
        if (cvalid_q && commit_ready) begin
            cvalid_d = 1'b0;
        end else begin
            cvalid_d = cvalid_q;
        end
        case (ev_s)
            EV_CLEAR: begin
                value_d = {VALUE_W{1'b0}};
                count_d = {COUNT_W{1'b0}};
            end
            EV_COMMIT: begin
                // A commit while an unaccepted word is pending is dropped.
                if (!cvalid_q || commit_ready) begin
                    cdata_d  = value_q;
                    cvalid_d = 1'b1;
                end else begin
                    cdata_d  = cdata_q;
                end
            end
            EV_ENTER: begin
                value_d = {value_q[VALUE_W-DIGIT_W-1:0], sw};
                if (count_q >= COUNT_MAX) begin
                    count_d = COUNT_MAX;
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end
            EV_NONE: begin
                value_d = value_q;
            end
            default: begin
                value_d = value_q;
            end
        endcase
    end

    // Action registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= {VALUE_W{1'b0}};
            count_q  <= {COUNT_W{1'b0}};
            cdata_q  <= {VALUE_W{1'b0}};
            cvalid_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            count_q  <= count_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign value        = value_q;
    assign digit_count  = count_q;
    assign commit_data  = cdata_q;
    assign commit_valid = cvalid_q;

endmodule

// File: doc/hex_entry.md
# hex_entry

Keypad-side counterpart of the seven-segment display path. It turns board push-buttons plus a 4-bit switch nibble into a 32-bit hexadecimal value, one digit per press. The live entry buffer drives the 8-digit display, so the operator sees digits as they are typed. A separate commit port hands the finished word to downstream logic over a valid/ready handshake.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz); legal range ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  4  hex digit to enter; static while a key is being pressed.
- key_enter_n  in  1  raw active-low button, asynchronous to clk: shift digit in.
- key_clear_n  in  1  raw active-low button: clear entry buffer.
- key_commit_n  in  1  raw active-low button: commit entry buffer.
- value  out  32  live entry buffer; display source, digit 0 = value[3:0].
- digit_count  out  4  digits entered since last clear, 0..8.
- commit_data  out  32  committed word, stable while commit_valid = 1.
- commit_valid  out  1  committed word available.
- commit_ready  in  1  consumer accepts commit_data when high together with commit_valid.

## Operation
- Each key passes through its own key_debounce instance: 2-flop synchronizer → stable-level filter → falling-edge detector. The detector emits one press pulse per debounced press. Release produces no event.
- Filter: a counter tracks synchronized ≠ debounced. The counter resets whenever the two agree. The debounced level takes the synchronized value on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
- Enter pulse: value ← {value[27:0], sw}; digit_count ← min(digit_count + 1, 8). Beyond 8 digits the most significant nibble is discarded and the count stays at 8.
- Clear pulse: value ← 0, digit_count ← 0. commit_data and commit_valid are unaffected.
- Commit pulse with commit_valid = 0, or with commit_valid = 1 and commit_ready = 1 in the same cycle: commit_data ← value, commit_valid ← 1. value is retained.
- Commit pulse with commit_valid = 1 and commit_ready = 0: the press is ignored and commit_data is unchanged.
- Handshake: commit_valid & commit_ready accepts the word. commit_valid falls the next cycle unless a new commit loads in that same cycle.
- Same-cycle priority: clear > commit > enter. The lower-priority pulses are dropped, not deferred.
- A held key produces exactly one event. The next event requires a debounced release followed by a debounced press.

## Timing
- Reset (async assert, synchronous-to-clk deassert is the board's responsibility) sets:
  - value = 0, digit_count = 0, commit_data = 0, commit_valid = 0;
  - synchronizer flops and debounced levels = 1 (released), debounce counters = 0.
  - No spurious event follows reset.
- Press latency: let edge N be the first edge whose synchronizer stage 1 samples low. The debounced level falls at edge N+DEBOUNCE_CYCLES+1. The action register update (value, commit_valid, ...) occurs at edge N+DEBOUNCE_CYCLES+2.
- Any bounce that restores agreement restarts the count from zero.
- A key held low through reset debounces afresh after reset release and generates one event DEBOUNCE_CYCLES+2 edges after release.
- Reset mid-operation aborts in-flight filtering. A pending commit is lost (commit_valid = 0).
- commit_ready is sampled only when commit_valid = 1. There is no combinational path from commit_ready to any output.

## Structure
- Shared package hex_entry_pkg holds:
  - NUM_DIGITS = 8, DIGIT_W = 4, COUNT_W = 4;
  - default DEBOUNCE_CYCLES;
  - the event priority constants.
- One sub-module, key_debounce, parameterized by DEBOUNCE_CYCLES and instantiated three times. Ports: clk, rst_n, key_n, level, press. Counter width is $clog2(DEBOUNCE_CYCLES).
- The top level holds only the entry buffer, digit counter, commit register and priority logic.

## Test plan
All tests run with DEBOUNCE_CYCLES = 4.
- Enter sw = 1..8, one clean press each → value = 0x12345678, digit_count = 8. Then enter 9 → value = 0x23456789, digit_count = 8.
- key_enter_n toggles every 2 cycles for 20 cycles, then holds low for 50 cycles with sw = 0xA → exactly one shift, value = 0x0000000A, pulse at edge N+6 after the final falling edge.
- Buffer 0xDEADBEEF, commit with commit_ready = 0 → commit_valid = 1, commit_data = 0xDEADBEEF. Clear, enter 0x5, commit again → ignored, commit_data unchanged. commit_ready = 1 for one cycle → commit_valid = 0 the next cycle.
- Clear and commit presses aligned to the same debounced edge with value = 0x00000077 → value = 0, digit_count = 0, commit_valid stays 0.
- Assert rst_n low mid-filter while key_enter_n is held low → all outputs 0 during reset. After release, exactly one shift occurs 6 edges later and no second shift while the key stays held.
- Hold key_commit_n low for 100 cycles, release for 10, press again, with commit_ready = 1 throughout → two distinct commit_valid assertions, each lasting exactly one cycle.
